// File: rtl/alu_uart_if_pkg.sv
// Shared types and constants for the UART <-> ALU bridge: FSM state encoding and ALU opcodes.
package alu_uart_if_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    LOAD    = 3'd3,
    WAIT_TX = 3'd4
  } state_e;

  localparam int unsigned ALU_OP_BITS = 6;

  localparam logic [ALU_OP_BITS-1:0] OP_ADD = 6'b100000;
  localparam logic [ALU_OP_BITS-1:0] OP_SUB = 6'b100010;
  localparam logic [ALU_OP_BITS-1:0] OP_AND = 6'b100100;
  localparam logic [ALU_OP_BITS-1:0] OP_OR  = 6'b100101;
  localparam logic [ALU_OP_BITS-1:0] OP_XOR = 6'b100110;
  localparam logic [ALU_OP_BITS-1:0] OP_SRA = 6'b000011;
  localparam logic [ALU_OP_BITS-1:0] OP_SRL = 6'b000010;
  localparam logic [ALU_OP_BITS-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_if_interbyte_timer.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the cycle in which the limit is hit.
module interbyte_timer #(
  parameter int unsigned TIMEOUT_TICKS = 50000,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned LIMIT = (TIMEOUT_TICKS == 0) ? 0 : TIMEOUT_TICKS - 1;

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  // Expiry fires only on an idle cycle at the limit; a zero limit disables it.
  assign o_expire_c = (TIMEOUT_TICKS != 0) && i_en && !i_clr && (cnt_q == CNT_BITS'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr || o_expire_c) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_uart_if.sv
// Collects A, B and opcode bytes from the UART RX, presents them to the ALU and
// forwards the ALU result to the UART TX with a one-cycle start pulse.
module alu_uart_if
  import alu_uart_if_pkg::*;
#(
  parameter int unsigned N_BITS        = 8,
  parameter int unsigned OP_BITS       = 6,
  parameter int unsigned TIMEOUT_TICKS = 50000,
  parameter int unsigned CNT_BITS      = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [N_BITS-1:0]  i_rx_data,
  input  logic               i_tx_done,
  input  logic [N_BITS-1:0]  i_alu_result,
  output logic [N_BITS-1:0]  o_dato_A,
  output logic [N_BITS-1:0]  o_dato_B,
  output logic [OP_BITS-1:0] o_operacion,
  output logic               o_tx_start,
  output logic [N_BITS-1:0]  o_tx_data,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_drop
);

  state_e               state_q, state_d;
  logic [N_BITS-1:0]    dato_a_q, dato_a_d;
  logic [N_BITS-1:0]    dato_b_q, dato_b_d;
  logic [OP_BITS-1:0]   op_q, op_d;
  logic [N_BITS-1:0]    tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic                 drop_q, drop_d;

  logic                 in_window;
  logic                 expire;

  // The watchdog only runs while a frame is partially received.
  assign in_window = (state_q == WAIT_B) || (state_q == WAIT_OP);

  interbyte_timer #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .CNT_BITS      (CNT_BITS)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clr      (!in_window || i_rx_done),
    .i_en       (in_window),
    .o_expire_c (expire)
  );

  always_comb begin
    state_d    = state_q;
    dato_a_d   = dato_a_q;
    dato_b_d   = dato_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    drop_d     = drop_q;

    case (state_q)
      WAIT_A: begin
        if (i_rx_done) begin
          dato_a_d = i_rx_data;
          state_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          dato_b_d = i_rx_data;
          state_d  = WAIT_OP;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          op_d    = i_rx_data[OP_BITS-1:0];
          state_d = LOAD;
        end else if (expire) begin
          timeout_d = 1'b1;
          state_d   = WAIT_A;
        end
      end
      LOAD: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
        if (i_rx_done) drop_d = 1'b1;
      end
      WAIT_TX: begin
        if (i_rx_done) drop_d = 1'b1;
        if (i_tx_done) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase

    busy_d = (state_d == LOAD) || (state_d == WAIT_TX);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= WAIT_A;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      drop_q     <= drop_d;
    end
  end

  assign o_dato_A    = dato_a_q;
  assign o_dato_B    = dato_b_q;
  assign o_operacion = op_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_timeout   = timeout_q;
  assign o_drop      = drop_q;

endmodule
